// File: rtl/prog_sequencer_pkg.sv
// rtl/prog_sequencer_pkg.sv - shared types, limits and entry-table helper for prog_sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    HALTED,
    EXHAUSTED
  } seq_state_t;

  localparam int MAX_PROGS = 4;
  localparam int MAX_PCW   = 32;

  // Slot idx of a table packed pcw bits per slot, slot 0 in the LSBs.
  function automatic logic [MAX_PCW-1:0] entry_addr(
    input logic [MAX_PROGS*MAX_PCW-1:0] tbl,
    input int                           pcw,
    input logic [2:0]                   idx
  );
    logic [MAX_PROGS*MAX_PCW-1:0] shifted;
    logic [MAX_PCW-1:0]           mask;
    shifted = tbl >> (int'(idx) * pcw);
    mask    = (pcw >= MAX_PCW) ? '1 : MAX_PCW'((33'd1 << pcw) - 33'd1);
    return MAX_PCW'(shifted) & mask;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - bench/sequencer control bundle with master and slave views
interface prog_sequencer_if #(
  parameter int PCW  = 16,
  parameter int CNTW = 24
) ();

  logic            START;
  logic            HALT_REQ;
  logic            PC_LOAD;
  logic [PCW-1:0]  PC_LOAD_ADDR;
  logic            PC_HOLD;
  logic            DONE;
  logic            TIMEOUT_FLAG;
  logic [1:0]      RUN_IDX;
  logic [CNTW-1:0] CYCLE_CNT;

  modport master (
    output START,
    output HALT_REQ,
    input  PC_LOAD,
    input  PC_LOAD_ADDR,
    input  PC_HOLD,
    input  DONE,
    input  TIMEOUT_FLAG,
    input  RUN_IDX,
    input  CYCLE_CNT
  );

  modport slave (
    input  START,
    input  HALT_REQ,
    output PC_LOAD,
    output PC_LOAD_ADDR,
    output PC_HOLD,
    output DONE,
    output TIMEOUT_FLAG,
    output RUN_IDX,
    output CYCLE_CNT
  );

endinterface

// File: rtl/prog_sequencer_edge_det.sv
// rtl/prog_sequencer_edge_det.sv - one-cycle delay of a level and its falling-edge pulse
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  logic din_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign fall = din_d & ~din;

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - run controller arming, running and halting resident programs on the PC
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int                         PCW         = 16,
  parameter int                         NUM_PROGS   = 3,
  // slice i holds the entry address of program i, slice 0 at the LSBs
  parameter logic [MAX_PROGS*PCW-1:0]   ENTRY_ADDRS = {16'd140, 16'd80, 16'd29, 16'd0},
  parameter int                         CNTW        = 24,
  parameter logic [CNTW-1:0]            TIMEOUT     = 24'hFFFFFF
) (
  input  logic             CLK,
  input  logic             RST_N,
  prog_sequencer_if.slave  bus
);

  localparam logic [MAX_PROGS*MAX_PCW-1:0] ENTRY_TBL = (MAX_PROGS*MAX_PCW)'(ENTRY_ADDRS);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [2:0]      next_idx_q;
  logic [1:0]      run_idx_q;
  logic [CNTW-1:0] cnt_q;
  logic            done_q;
  logic            tflag_q;

  logic            start_fall;
  logic            all_used;
  logic            at_limit;
  logic            arm_entry;
  logic            run_to_halt;
  logic            pc_load;
  logic            pc_hold;

  edge_det u_start_edge (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (bus.START),
    .fall  (start_fall)
  );

  assign all_used    = (next_idx_q == 3'(NUM_PROGS));
  assign at_limit    = (cnt_q == TIMEOUT - CNTW'(1));
  assign arm_entry   = (state_d == ARMED) && (state_q != ARMED);
  assign run_to_halt = (state_q == RUN) && (state_d == HALTED);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // START in RUN aborts the current program and takes priority over HALT_REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.START) state_d = all_used ? EXHAUSTED : ARMED;
      end
      ARMED: begin
        if (start_fall) state_d = RUN;
      end
      RUN: begin
        if (bus.START)                      state_d = all_used ? EXHAUSTED : ARMED;
        else if (bus.HALT_REQ || at_limit)  state_d = HALTED;
      end
      EXHAUSTED: state_d = EXHAUSTED;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_load = 1'b0;
    pc_hold = 1'b1;
    case (state_q)
      ARMED: begin
        pc_load = 1'b1;
        pc_hold = 1'b0;
      end
      RUN:     pc_hold = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      next_idx_q <= 3'd0;
      run_idx_q  <= 2'd0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      tflag_q    <= 1'b0;
    end else begin
      if (arm_entry) begin
        run_idx_q <= next_idx_q[1:0];
        cnt_q     <= '0;
        done_q    <= 1'b0;
        tflag_q   <= 1'b0;
      end
      if ((state_q == ARMED) && (state_d == RUN)) begin
        next_idx_q <= next_idx_q + 3'd1;
      end
      // The cycle that ends the run (halt or watchdog) is still counted.
      if ((state_q == RUN) && ((state_d == RUN) || (state_d == HALTED)) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
      if (run_to_halt) begin
        tflag_q <= ~bus.HALT_REQ;
      end
      if (((state_d == HALTED) || (state_d == EXHAUSTED)) && (state_q != state_d)) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bus.PC_LOAD      = pc_load;
  assign bus.PC_HOLD      = pc_hold;
  assign bus.PC_LOAD_ADDR = pc_load ? PCW'(entry_addr(ENTRY_TBL, PCW, next_idx_q)) : '0;
  assign bus.DONE         = done_q;
  assign bus.TIMEOUT_FLAG = tflag_q;
  assign bus.RUN_IDX      = run_idx_q;
  assign bus.CYCLE_CNT    = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - scoreboard bench for prog_sequencer with a program-level reference model
module tb_prog_sequencer;

  localparam int TMO   = 50;
  localparam int NPROG = 3;

  typedef enum int {EV_ARM, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       addr;
    int       idx;
    int       cnt;
    int       tflag;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_ev;
  int   tbl[4] = '{0, 29, 80, 140};
  int   n_total = 0;
  int   n_pass = 0;
  int   model_idx = 0;
  int   last_cnt = 0;
  int   last_tflag = 0;
  logic prev_load = 1'b0;
  logic prev_done = 1'b0;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  prog_sequencer_if #(.PCW(16), .CNTW(24)) bus ();

  prog_sequencer #(
    .PCW         (16),
    .NUM_PROGS   (NPROG),
    .ENTRY_ADDRS (64'h008C_0050_001D_0000),
    .CNTW        (24),
    .TIMEOUT     (24'd50)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_ev(input ev_kind_t kind, input int addr, input int idx, input int cnt, input int tflag);
    ev_t e;
    e.kind = kind; e.addr = addr; e.idx = idx; e.cnt = cnt; e.tflag = tflag;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every arm (PC_LOAD rise) and completion (DONE rise) must match the next expected event.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_load = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.PC_LOAD && !prev_load) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL arm_event: got unexpected PC_LOAD rise, expected none");
        end else begin
          mon_ev = sb.pop_front();
          check("arm_kind", int'(bus.PC_LOAD), (mon_ev.kind == EV_ARM) ? 1 : 0);
          check("arm_addr", int'(bus.PC_LOAD_ADDR), mon_ev.addr);
          check("arm_run_idx", int'(bus.RUN_IDX), mon_ev.idx);
          check("arm_cycle_cnt", int'(bus.CYCLE_CNT), 0);
          check("arm_done", int'(bus.DONE), 0);
        end
      end
      if (bus.DONE && !prev_done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL done_event: got unexpected DONE rise, expected none");
        end else begin
          mon_ev = sb.pop_front();
          check("done_kind", int'(bus.DONE), (mon_ev.kind == EV_DONE) ? 1 : 0);
          check("done_cycle_cnt", int'(bus.CYCLE_CNT), mon_ev.cnt);
          check("done_timeout_flag", int'(bus.TIMEOUT_FLAG), mon_ev.tflag);
          check("done_run_idx", int'(bus.RUN_IDX), mon_ev.idx);
          check("done_pc_hold", int'(bus.PC_HOLD), 1);
        end
      end
      if (!bus.PC_LOAD) check("addr_zero_when_idle", int'(bus.PC_LOAD_ADDR), 0);
      prev_load = bus.PC_LOAD;
      prev_done = bus.DONE;
    end
  end

  task automatic do_reset();
    check("sb_empty_before_reset", sb.size(), 0);
    sb.delete();
    bus.START = 1'b0;
    bus.HALT_REQ = 1'b0;
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    model_idx = 0;
    check("rst_pc_load", int'(bus.PC_LOAD), 0);
    check("rst_pc_hold", int'(bus.PC_HOLD), 1);
    check("rst_done", int'(bus.DONE), 0);
    check("rst_timeout_flag", int'(bus.TIMEOUT_FLAG), 0);
    check("rst_run_idx", int'(bus.RUN_IDX), 0);
    check("rst_cycle_cnt", int'(bus.CYCLE_CNT), 0);
    check("rst_load_addr", int'(bus.PC_LOAD_ADDR), 0);
  endtask

  // START held for len sampled edges, then dropped; returns in the first RUN cycle.
  task automatic arm(input int len, input bit with_halt);
    push_ev(EV_ARM, tbl[model_idx], model_idx, 0, 0);
    bus.START = 1'b1;
    bus.HALT_REQ = with_halt;
    for (int c = 0; c < len; c++) begin
      tick();
      bus.HALT_REQ = 1'b0;
      check("armed_pc_load", int'(bus.PC_LOAD), 1);
      check("armed_addr", int'(bus.PC_LOAD_ADDR), tbl[model_idx]);
      check("armed_pc_hold", int'(bus.PC_HOLD), 0);
      check("armed_done", int'(bus.DONE), 0);
    end
    bus.START = 1'b0;
    model_idx++;
    tick();
  endtask

  // kind 0: HALT_REQ on RUN cycle h; kind 1: no halt, watchdog ends it; kind 2: return on RUN cycle h still running.
  task automatic run_prog(input int kind, input int h);
    int  k;
    bit  fin;
    k = 1;
    fin = 1'b0;
    while (!fin) begin
      check("run_cycle_cnt", int'(bus.CYCLE_CNT), k - 1);
      check("run_pc_load", int'(bus.PC_LOAD), 0);
      check("run_pc_hold", int'(bus.PC_HOLD), 0);
      check("run_done", int'(bus.DONE), 0);
      if (kind == 2 && k == h) return;
      if (kind == 0 && k == h) begin
        bus.HALT_REQ = 1'b1;
        last_cnt = h;
        last_tflag = 0;
        push_ev(EV_DONE, 0, model_idx - 1, last_cnt, last_tflag);
        fin = 1'b1;
      end else if (k == TMO) begin
        last_cnt = TMO;
        last_tflag = 1;
        push_ev(EV_DONE, 0, model_idx - 1, last_cnt, last_tflag);
        fin = 1'b1;
      end
      tick();
      bus.HALT_REQ = 1'b0;
      k++;
    end
  endtask

  task automatic idle_gap(input int n, input bit poke_halt);
    for (int i = 0; i < n; i++) begin
      check("halted_done", int'(bus.DONE), 1);
      check("halted_pc_hold", int'(bus.PC_HOLD), 1);
      check("halted_pc_load", int'(bus.PC_LOAD), 0);
      check("halted_cycle_cnt", int'(bus.CYCLE_CNT), last_cnt);
      check("halted_timeout_flag", int'(bus.TIMEOUT_FLAG), last_tflag);
      bus.HALT_REQ = (poke_halt && i == n / 2);
      tick();
      bus.HALT_REQ = 1'b0;
    end
  endtask

  task automatic exhaust_check();
    bus.START = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("exh_pc_load", int'(bus.PC_LOAD), 0);
      check("exh_done", int'(bus.DONE), 1);
      check("exh_pc_hold", int'(bus.PC_HOLD), 1);
      check("exh_run_idx", int'(bus.RUN_IDX), NPROG - 1);
      check("exh_cycle_cnt", int'(bus.CYCLE_CNT), last_cnt);
      bus.START = (i < 1 || i == 5);
      bus.HALT_REQ = (i == 3);
      tick();
    end
    bus.START = 1'b0;
    bus.HALT_REQ = 1'b0;
  endtask

  initial begin
    int len;
    int kind;
    int h;
    bus.START = 1'b0;
    bus.HALT_REQ = 1'b0;
    do_reset();

    arm(3, 1'b0); run_prog(0, 10);  idle_gap(20, 1'b0);
    arm(2, 1'b0); run_prog(0, 5);   idle_gap(3, 1'b1);
    arm(1, 1'b0); run_prog(0, TMO); idle_gap(3, 1'b0);
    exhaust_check();

    do_reset();
    arm(2, 1'b0); run_prog(2, 8);
    arm(2, 1'b1); run_prog(1, 0); idle_gap(4, 1'b1);

    do_reset();
    arm(1, 1'b0); run_prog(0, 3); idle_gap(2, 1'b0);
    arm(1, 1'b0); run_prog(2, 4);
    do_reset();
    arm(1, 1'b0); run_prog(0, 2); idle_gap(2, 1'b0);

    repeat (4) begin
      do_reset();
      while (model_idx < NPROG) begin
        len = int'($urandom_range(1, 4));
        arm(len, 1'($urandom_range(0, 1)));
        kind = int'($urandom_range(0, 2));
        if (kind == 2 && model_idx == NPROG) kind = 0;
        h = (kind == 0) ? int'($urandom_range(1, TMO)) : int'($urandom_range(1, TMO - 1));
        run_prog(kind, h);
        if (kind != 2) idle_gap(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end
      exhaust_check();
    end

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
